// File: rtl/fib_seq_ctrl_if.sv
// Request/response bundle for fib_seq_ctrl: request handshake with index,
// abort, and the result handshake with data/overflow plus a busy status.
interface fib_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [4:0]       req_n;
    logic             abort;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ovf;
    logic             busy;

    modport master (
        output req_valid, req_n, abort, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_ovf, busy
    );

    modport slave (
        input  req_valid, req_n, abort, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_ovf, busy
    );
endinterface

// File: rtl/fib_seq_ctrl.sv
// Iterative Fibonacci controller: computes F(n) mod 2^WIDTH with an overflow flag.
// Define FIB_SAT_EN to saturate rsp_data to all ones when F(n) overflows.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RUN   | stepping a/b once per cycle until cnt reaches zero
// DONE  | result held on rsp_data/rsp_ovf until the consumer takes it
module fib_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    fib_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             ova_q, ova_d;
    logic             ovb_q, ovb_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum;

    // Single ripple-carry adder shared by every RUN step; sum[WIDTH] is the carry out.
    always_comb begin : adder
        logic carry;
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a_q[i] ^ b_q[i] ^ carry;
            carry  = (a_q[i] & b_q[i]) | (carry & (a_q[i] ^ b_q[i]));
        end
        sum[WIDTH] = carry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            ova_q   <= 1'b0;
            ovb_q   <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            ova_q   <= ova_d;
            ovb_q   <= ovb_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        ova_d   = ova_q;
        ovb_d   = ovb_q;
        data_d  = data_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = RUN;
                    a_d     = '0;
                    b_d     = {{(WIDTH-1){1'b0}}, 1'b1};
                    cnt_d   = bus.req_n;
                    ova_d   = 1'b0;
                    ovb_d   = 1'b0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_q == 5'd0) begin
                    state_d = DONE;
                    ovf_d   = ova_q;
`ifdef FIB_SAT_EN
                    data_d  = ova_q ? {WIDTH{1'b1}} : a_q;
`else
                    data_d  = a_q;
`endif
                end else begin
                    a_d   = b_q;
                    b_d   = sum[WIDTH-1:0];
                    cnt_d = cnt_q - 5'd1;
                    ova_d = ovb_q;
                    // ova/ovb follow a/b: once a term overflows, every later term does too.
                    ovb_d = ovb_q | ova_q | sum[WIDTH];
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl: arithmetic reference model compared every
// cycle, plus directed requests with hand-computed results and latencies.
module tb_fib_seq_ctrl;
    localparam int W = 8;
    localparam longint MAXV = (64'd1 << W) - 1;
`ifdef FIB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    fib_seq_ctrl_if #(.WIDTH(W)) bus ();

    fib_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint fib(input int n);
        longint x = 0, y = 1, t;
        for (int k = 0; k < n; k++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Reference model: idle / computing (cycles left) / holding a result.
    bit     chk_en = 1'b0;
    bit     m_idle = 1'b1;
    bit     m_rsp  = 1'b0;
    int     m_left = 0;
    int     m_n    = 0;
    longint m_data = 0;
    bit     m_ovf  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_idle <= 1'b1;
            m_rsp  <= 1'b0;
            m_left <= 0;
            m_data <= 0;
            m_ovf  <= 1'b0;
            chk_en <= 1'b1;
        end else if (m_rsp) begin
            if (bus.rsp_ready) begin
                m_rsp  <= 1'b0;
                m_idle <= 1'b1;
            end
        end else if (!m_idle) begin
            if (bus.abort) begin
                m_idle <= 1'b1;
            end else if (m_left == 0) begin
                m_rsp  <= 1'b1;
                m_ovf  <= (fib(m_n) > MAXV);
                m_data <= (SAT && fib(m_n) > MAXV) ? MAXV : (fib(m_n) % (MAXV + 1));
            end else begin
                m_left <= m_left - 1;
            end
        end else if (bus.req_valid) begin
            m_idle <= 1'b0;
            m_left <= int'(bus.req_n);
            m_n    <= int'(bus.req_n);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_req_ready", bus.req_ready, m_idle);
            chk("m_rsp_valid", bus.rsp_valid, m_rsp);
            chk("m_busy",      bus.busy,      !m_idle);
            chk("m_rsp_data",  bus.rsp_data,  m_data);
            chk("m_rsp_ovf",   bus.rsp_ovf,   m_ovf);
        end
    end

    task automatic run_req(input int n, input int exp_d, input int exp_o,
                           input int exp_lat, input bit hold_ready);
        int lat;
        @(negedge clk);
        chk($sformatf("idle_before_n%0d", n), bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_n     = 5'(n);
        bus.rsp_ready = hold_ready;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency_n%0d", n), lat, exp_lat);
        chk($sformatf("data_n%0d", n), bus.rsp_data, exp_d);
        chk($sformatf("ovf_n%0d", n), bus.rsp_ovf, exp_o);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_n     = '0;
        bus.abort     = 1'b0;
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", bus.req_ready, 1);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_busy",      bus.busy,      0);

        run_req(0, 0, 0, 1, 1'b1);
        run_req(1, 1, 0, 2, 1'b1);
        run_req(10, 55, 0, 11, 1'b1);
        @(negedge clk);
        chk("ready_after_n10", bus.req_ready, 1);
        run_req(13, 233, 0, 14, 1'b1);
        run_req(14, SAT ? 255 : 121, 1, 15, 1'b1);
        run_req(31, SAT ? 255 : 221, 1, 32, 1'b1);

        // Backpressure with an ignored request and an ignored abort during the stall.
        run_req(7, 13, 0, 8, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.abort     = (i == 1);
            bus.req_valid = (i == 2);
            bus.req_n     = 5'd3;
            chk("stall_valid", bus.rsp_valid, 1);
            chk("stall_data",  bus.rsp_data,  13);
        end
        bus.abort     = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_valid", bus.rsp_valid, 0);
        chk("stall_release_ready", bus.req_ready, 1);
        repeat (3) @(negedge clk);
        chk("stall_no_queued_req", bus.busy, 0);

        // Abort mid-run.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_n     = 5'd20;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_req_ready", bus.req_ready, 1);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        repeat (25) @(negedge clk);
        chk("abort_no_rsp", bus.rsp_valid, 0);

        // Reset mid-run.
        bus.req_valid = 1'b1;
        bus.req_n     = 5'd20;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data",  bus.rsp_data,  0);
        chk("rst_rsp_ovf",   bus.rsp_ovf,   0);
        chk("rst_busy",      bus.busy,      0);
        repeat (25) @(negedge clk);
        chk("rst_no_rsp", bus.rsp_valid, 0);

        run_req(6, 8, 0, 7, 1'b1);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
